// File: rtl/msx_reset_ctrl.sv
// rtl/msx_reset_ctrl.sv - MSX system reset sequencer: power-on, cold request and debounced warm button
// Optional keyboard hotkey reset input is enabled by defining RESET_CTRL_KEYB_EN.
module msx_reset_ctrl #(
  parameter int STRETCH_CYCLES  = 1024,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_ready,
  input  logic cold_req,
  input  logic warm_btn,
`ifdef RESET_CTRL_KEYB_EN
  input  logic keyb_reset,
`endif
  output logic reset_out,
  output logic cold_boot,
  output logic reset_done
);

  localparam int SW = $clog2(STRETCH_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SW-1:0] ST_LAST = SW'(STRETCH_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_POR,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t        state;
  logic [SW-1:0] st_cnt;
  logic [DW-1:0] db_cnt;
  logic          btn_meta;
  logic          btn_sync;
  logic          btn_db;
  logic          btn_db_q;
  logic          warm_rise;
  logic          warm_hold;
  logic          hold_cond;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= warm_btn;
      btn_sync <= btn_meta;
    end
  end

  // The debounced value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

`ifdef RESET_CTRL_KEYB_EN
  logic keyb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyb_q <= 1'b0;
    end else begin
      keyb_q <= keyb_reset;
    end
  end

  assign warm_rise = (btn_db & ~btn_db_q) | (keyb_reset & ~keyb_q);
  assign warm_hold = btn_db | keyb_reset;
`else
  assign warm_rise = btn_db & ~btn_db_q;
  assign warm_hold = btn_db;
`endif

  assign hold_cond = cold_req | warm_hold | ~mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_POR;
      st_cnt     <= '0;
      reset_out  <= 1'b1;
      cold_boot  <= 1'b1;
      reset_done <= 1'b0;
    end else begin
      reset_done <= 1'b0;
      case (state)
        ST_POR: begin
          reset_out <= 1'b1;
          cold_boot <= 1'b1;
          st_cnt    <= '0;
          if (mem_ready) begin
            state <= ST_HOLD;
            // This cycle already counts toward the stretch when nothing else is holding.
            if (!(cold_req | warm_hold)) begin
              st_cnt <= SW'(1);
            end
          end
        end
        ST_HOLD: begin
          reset_out <= 1'b1;
          if (cold_req) begin
            cold_boot <= 1'b1;
          end
          if (hold_cond) begin
            st_cnt <= '0;
          end else if (st_cnt >= ST_LAST) begin
            state      <= ST_RUN;
            st_cnt     <= '0;
            reset_out  <= 1'b0;
            reset_done <= 1'b1;
          end else begin
            st_cnt <= st_cnt + SW'(1);
          end
        end
        ST_RUN: begin
          reset_out <= 1'b0;
          if (cold_req) begin
            state     <= ST_HOLD;
            st_cnt    <= '0;
            reset_out <= 1'b1;
            cold_boot <= 1'b1;
          end else if (warm_rise) begin
            state     <= ST_HOLD;
            st_cnt    <= '0;
            reset_out <= 1'b1;
            cold_boot <= 1'b0;
          end
        end
        default: begin
          state     <= ST_POR;
          st_cnt    <= '0;
          reset_out <= 1'b1;
          cold_boot <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/msx_reset_ctrl.md
# msx_reset_ctrl

Reset sequencer that generates the MSX system reset driven onto `cpu_bus.reset`, which clears every bus device, including the reset-status I/O latches. It merges the platform power-on reset, an OSD/core cold-reset request and a debounced front-panel warm-reset button into one stretched, glitch-free reset. It also reports whether the last reset was cold or warm, so software-visible status (e.g. the cold/warm bit of the reset-status port) can be seeded correctly.

## Interface
Parameters:
- `STRETCH_CYCLES`, default 1024: minimum `reset_out` high time after the last active request, in `clk` cycles (≥2).
- `DEBOUNCE_CYCLES`, default 65536: consecutive stable cycles required before the synchronised button input is accepted (≥2).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high (platform/PLL-lock reset).
- `mem_ready`  in  1  synchronous; SDRAM/ROM loader ready. Reset is not released while low.
- `cold_req`  in  1  synchronous level or pulse; requests a cold reset.
- `warm_btn`  in  1  asynchronous raw button, active-high.
- `reset_out`  out  1  system reset to the bus, active-high, registered.
- `cold_boot`  out  1  1 means the current or most recent reset was cold. Registered.
- `reset_done`  out  1  one-cycle pulse on the cycle `reset_out` falls.

## Operation
- `warm_btn` passes through a 2-flop synchroniser, then a debouncer. The debounced value `btn_db` changes only after the synchronised input differs from `btn_db` for `DEBOUNCE_CYCLES` consecutive cycles. The debounce counter clears whenever the synchronised input equals `btn_db`.
- States:
  - POR: entered on async `reset`. `reset_out`=1, `cold_boot`=1. Go to HOLD when `mem_ready`=1.
  - HOLD: `reset_out`=1. The stretch counter increments each cycle.
    - It clears while `cold_req`=1, while `btn_db`=1, or while `mem_ready`=0.
    - When the counter reaches `STRETCH_CYCLES`-1 and none of those conditions holds, go to RUN.
  - RUN: `reset_out`=0.
    - `cold_req`=1: go to HOLD, set `cold_boot`=1, clear the counter.
    - Rising edge of `btn_db` (with `cold_req`=0): go to HOLD, set `cold_boot`=0, clear the counter.
- Priority: a cold request beats a warm request in the same cycle, so `cold_boot`=1.
- Within HOLD, `cold_req` sets `cold_boot`=1. A warm press never downgrades a pending cold reset to warm.
- `cold_boot` holds its value in RUN until the next reset entry.
- `reset_done` is 1 only on the HOLD→RUN transition cycle, registered with `reset_out`.
- Counter widths: `$clog2(STRETCH_CYCLES)` and `$clog2(DEBOUNCE_CYCLES)+1` bits. Counters saturate and never wrap.

## Timing
- Reset values: `reset_out`=1, `cold_boot`=1, `reset_done`=0, state POR, both counters 0, synchroniser flops 0, `btn_db`=0.
- `cold_req` sampled in RUN at cycle N gives `reset_out`=1 at N+1.
- With no further requests and `mem_ready`=1, `reset_out` falls exactly `STRETCH_CYCLES` cycles after the last cycle in which any hold condition was active.
- Button latency: 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1 registered cycle to `reset_out`=1.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no reset.
- `mem_ready` dropping in RUN has no effect. It is only examined in POR and HOLD.
- Async `reset` at any time returns to POR in the same instant, regardless of state or counters.

## Configuration
- `RESET_CTRL_KEYB_EN` defined:
  - Adds input `keyb_reset` (1 bit, synchronous), driven by the keyboard hotkey decoder.
  - A rising edge in RUN acts as a warm request; holding it keeps HOLD active.
  - It bypasses the debouncer and has lower priority than `cold_req`.
- `RESET_CTRL_KEYB_EN` undefined: the port does not exist and behaviour is exactly as described above.

## Test plan
Use `STRETCH_CYCLES`=8 and `DEBOUNCE_CYCLES`=4 throughout.
- Power-on: `reset` pulse with `mem_ready`=0 for 20 cycles, then 1. Required: `reset_out`=1 throughout; it falls 8 cycles after `mem_ready` rises; `cold_boot`=1; `reset_done` pulses once.
- Warm press: `warm_btn` high for 10 cycles in RUN. Required: `reset_out` rises 7 cycles after the press (2 sync + 4 debounce + 1), stays high while `btn_db`=1, and falls 8 cycles after `btn_db` falls; `cold_boot`=0.
- Glitch: `warm_btn` high for 3 cycles. Required: `reset_out` stays 0 and `btn_db` never changes.
- Priority: `cold_req` and a `btn_db` rising edge in the same RUN cycle. Required: `cold_boot`=1. A later button press during that HOLD leaves `cold_boot`=1.
- Re-trigger: `cold_req` pulsed on stretch count 5. Required: the counter restarts and release occurs 8 cycles after the pulse.
- Mid-operation async reset during HOLD with a warm cause. Required: immediate POR, `cold_boot`=1, all counters 0.
